fmac_pktctrl_wr_arb: RTL

//  Round-robin write arbiter in front of the shared 4Kx8 packet-control FIFO (fmac_fifo4Kx8).
//  Up to NUM_REQ requesters each offer fixed-length control records (REC_LEN bytes).
//  A requester is granted only when the FIFO can hold its whole record, so records never interleave.
//  The block then streams the granted record byte by byte into the FIFO write port.

---
 rtl/fmac_pktctrl_pkg.sv | 19 +
 rtl/fmac_rr_pick.sv | 30 +++
 rtl/fmac_pktctrl_wr_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fmac_pktctrl_pkg.sv
// Shared types and constants for the packet-control FIFO write arbiter.
// Holds the FSM encoding, the post-record gap length and the stats counter width.
package fmac_pktctrl_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_XFER = 2'd1;
    localparam arb_state_t ST_GAP  = 2'd2;

    localparam int GAP_CYC = 2;
    localparam int STAT_W  = 16;

    // Next round-robin start position after granting idx, wrapping at num.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int num);
        return (int'(idx) == num - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/fmac_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
// Produces the winner as both a one-hot vector and an index.
module fmac_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         rr_ptr,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [2:0]         pick_idx,
    output logic               pick_valid
);

    // Scan from the farthest position back to rr_ptr so the nearest candidate wins.
    always_comb begin
        pick_oh    = '0;
        pick_idx   = 3'd0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(rr_ptr) + k) % NUM_REQ && req[i]) begin
                    pick_valid = 1'b1;
                    pick_idx   = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            pick_oh[i] = pick_valid && (pick_idx == 3'(i));
    end

endmodule

// File: rtl/fmac_pktctrl_wr_arb.sv
// Round-robin writer of whole fixed-length control records into the shared packet-control FIFO.
// Optional FMAC_PKTCTRL_ARB_STATS_EN adds per-requester record counters and a space-stall counter.
module fmac_pktctrl_wr_arb
    import fmac_pktctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REC_LEN = 8,
    parameter int DEPTH   = 4096,
    parameter int PTR     = 12
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   proto_err,
    output logic                   fifo_wrreq,
    output logic [7:0]             fifo_data,
    input  logic                   fifo_wrfull,
    input  logic [PTR:0]           fifo_wrusedw,
    output logic                   busy,
    output logic [2:0]             gnt_id
`ifdef FMAC_PKTCTRL_ARB_STATS_EN
    ,
    output logic [STAT_W*NUM_REQ-1:0] stat_rec_cnt,
    output logic [STAT_W-1:0]         stat_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(REC_LEN);

    arb_state_t           state;
    logic [2:0]           rr_ptr;
    logic [CNT_W-1:0]     byte_cnt;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 dropped;
    logic [1:0]           gap_cnt;

    logic [PTR+1:0]       free_space;
    logic                 space_ok;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [2:0]           pick_idx;
    logic                 pick_valid;
    logic                 in_xfer;
    logic                 accept;
    logic                 gnt_live;
    logic                 last_byte;
    logic [7:0]           lane_byte;

    // A record is only started when the whole of it fits, so records never interleave.
    assign free_space = (PTR+2)'(DEPTH) - {1'b0, fifo_wrusedw};
    assign space_ok   = free_space >= (PTR+2)'(REC_LEN);
    assign elig       = req & {NUM_REQ{space_ok & ~fifo_wrfull}};

    fmac_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (elig),
        .rr_ptr     (rr_ptr),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        lane_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_oh[i]) lane_byte = req_data[i*8 +: 8];
    end

    assign in_xfer   = (state == ST_XFER);
    assign accept    = in_xfer & ~fifo_wrfull;
    assign gnt_live  = |(req & gnt_oh) & ~dropped;
    assign last_byte = (byte_cnt == CNT_W'(REC_LEN - 1));

    // After a dropped request the record is padded with zeros so the FIFO still sees REC_LEN bytes.
    assign fifo_wrreq = accept;
    assign fifo_data  = (in_xfer && gnt_live) ? lane_byte : 8'h00;
    assign req_ack    = (accept && gnt_live) ? gnt_oh : '0;
    assign req_done   = (accept && gnt_live && last_byte) ? gnt_oh : '0;
    assign proto_err  = in_xfer & ~dropped & ~(|(req & gnt_oh));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= ST_IDLE;
            rr_ptr   <= 3'd0;
            byte_cnt <= '0;
            gnt_id   <= 3'd0;
            gnt_oh   <= '0;
            dropped  <= 1'b0;
            gap_cnt  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_id   <= pick_idx;
                        gnt_oh   <= pick_oh;
                        byte_cnt <= '0;
                        dropped  <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (proto_err)
                        dropped <= 1'b1;
                    if (accept) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            gap_cnt  <= 2'd0;
                            rr_ptr   <= rr_next(gnt_id, NUM_REQ);
                            state    <= ST_GAP;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    // Idle gap lets fifo_wrusedw catch up before the next space check.
                    if (gap_cnt == 2'(GAP_CYC - 1))
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 2'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FMAC_PKTCTRL_ARB_STATS_EN
    logic stall_cycle;
    assign stall_cycle = (state == ST_IDLE) && (|req) && !pick_valid;

    // Saturating counters: completed records per requester and space/full stalls.
    always_ff @(posedge clk) begin
        if (srst) begin
            stat_rec_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_done[i] && stat_rec_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                    stat_rec_cnt[i*STAT_W +: STAT_W] <= stat_rec_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
            if (stall_cycle && stat_stall_cnt != {STAT_W{1'b1}})
                stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
        end
    end
`endif

endmodule
